// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative MULT/DIV datapath; owns HI/LO. Result lands CYCLES+2 edges after start.
// No queuing: start is only sampled in IDLE, busy stalls the control unit, DIV by zero is rejected with a pulse.
module muldiv_ctrl #(
  parameter int CYCLES = 32,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dp_reset,
  output logic        dp_step,
  output logic        dp_op,
  output logic [31:0] dp_A,
  output logic [31:0] dp_B,
  input  logic [31:0] dp_HI,
  input  logic [31:0] dp_LO
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             reject;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    busy      = (state != IDLE);
    dp_reset  = reset || (state == LOAD);
    dp_step   = (state == RUN);
    case (state)
      IDLE: begin
        if (start) begin
          if (op && (in_B == '0)) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(CYCLES - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      HI       <= '0;
      LO       <= '0;
      dp_op    <= 1'b0;
      dp_A     <= '0;
      dp_B     <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= (state == CAPTURE);
      div_zero <= reject;

      if (state == LOAD)      cnt <= '0;
      else if (state == RUN)  cnt <= cnt + 1'b1;

      if (accept) begin
        dp_op <= op;
        dp_A  <= in_A;
        dp_B  <= in_B;
      end

      // MTHI/MTLO only land while idle; a start in the same cycle is later overwritten by CAPTURE
      if (state == CAPTURE) begin
        HI <= dp_HI;
        LO <= dp_LO;
      end else if (state == IDLE) begin
        if (wr_hi) HI <= wr_data;
        if (wr_lo) LO <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural step-counting datapath plus arithmetic reference for MULT/DIV results.
module tb_muldiv_ctrl;
  localparam int CYCLES = 32;
  localparam int LAT    = CYCLES + 2;

  logic        clk = 1'b0;
  logic        reset, start, op, wr_hi, wr_lo;
  logic [31:0] in_A, in_B, wr_data;
  logic        busy, done, div_zero, dp_reset, dp_step, dp_op;
  logic [31:0] HI, LO, dp_A, dp_B, dp_HI, dp_LO;

  int vectors     = 0;
  int miscompares = 0;

  muldiv_ctrl #(.CYCLES(CYCLES), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_A(in_A), .in_B(in_B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO),
    .dp_reset(dp_reset), .dp_step(dp_step), .dp_op(dp_op), .dp_A(dp_A), .dp_B(dp_B),
    .dp_HI(dp_HI), .dp_LO(dp_LO)
  );

  always #5 clk = ~clk;

  // Signed MULT gives the 64-bit product; signed DIV gives {remainder, quotient}
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    if (!o) begin
      p = $signed(a) * $signed(b);
      return p;
    end
    if (b == 32'd0) return 64'd0;
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  // Datapath model: result is only valid after exactly CYCLES steps since its last reset
  int          steps;
  logic [63:0] dp_res;
  always @(posedge clk) begin
    if (dp_reset)     steps <= 0;
    else if (dp_step) steps <= steps + 1;
  end
  always_comb begin
    dp_res = ref_result(dp_op, dp_A, dp_B);
    if (steps == CYCLES) begin
      dp_HI = dp_res[63:32];
      dp_LO = dp_res[31:0];
    end else begin
      dp_HI = 32'hBAD0_0000 ^ 32'(steps);
      dp_LO = 32'h0BAD_0000 ^ 32'(steps);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in_A = a; in_B = b;
    tick;
    start = 1'b0;
  endtask

  // Advances n_cyc cycles, tallying activity and latched-operand stability
  task automatic watch_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                          input int n_cyc, output int busy_n, output int step_n, output int done_n,
                          output int dp_bad);
    busy_n = 0; step_n = 0; done_n = 0; dp_bad = 0;
    for (int n = 0; n < n_cyc; n++) begin
      busy_n += int'(busy);
      step_n += int'(dp_step);
      done_n += int'(done);
      if (dp_A !== a || dp_B !== b || dp_op !== o) dp_bad++;
      if (scramble) begin
        in_A = $urandom; in_B = $urandom; op = 1'($urandom);
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; in_A = '0; in_B = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    tick; tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0 || div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: done %b div_zero %b want 0 0", done, div_zero); end
    vectors++; if (HI !== 32'd0 || LO !== 32'd0) begin miscompares++; $display("FAIL reset_hilo: got %h %h want 0 0", HI, LO); end
    vectors++; if (dp_A !== 32'd0 || dp_B !== 32'd0 || dp_op !== 1'b0) begin miscompares++; $display("FAIL reset_dp: got %h %h %b want 0 0 0", dp_A, dp_B, dp_op); end
    vectors++; if (dp_reset !== 1'b1 || dp_step !== 1'b0) begin miscompares++; $display("FAIL reset_dpctl: dp_reset %b dp_step %b want 1 0", dp_reset, dp_step); end
    reset = 1'b0;
    tick;
    vectors++; if (dp_reset !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_release: dp_reset %b busy %b want 0 0", dp_reset, busy); end
  endtask

  task automatic test_mult_basic;
    int b_n, s_n, d_n, bad;
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    vectors++; if (dp_reset !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL mult_load: dp_reset %b busy %b want 1 1", dp_reset, busy); end
    watch_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, LAT, b_n, s_n, d_n, bad);
    vectors++; if (b_n !== LAT) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d want %0d", b_n, LAT); end
    vectors++; if (s_n !== CYCLES) begin miscompares++; $display("FAIL mult_step_cycles: got %0d want %0d", s_n, CYCLES); end
    vectors++; if (d_n !== 0 || done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mult_done_edge: early %0d done %b busy %b want 0 1 0", d_n, done, busy); end
    vectors++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_result: got %h_%h want ffffffff_ffffffeb", HI, LO); end
    tick;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mult_done_width: got %b want 0", done); end
  endtask

  task automatic test_div_basic;
    int b_n, s_n, d_n, bad;
    issue(1'b1, 32'd100, 32'd7);
    watch_op(1'b1, 32'd100, 32'd7, 1'b1, LAT, b_n, s_n, d_n, bad);
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL div_operand_hold: %0d unstable cycles want 0", bad); end
    vectors++; if (done !== 1'b1 || d_n !== 0) begin miscompares++; $display("FAIL div_done_edge: done %b early %0d want 1 0", done, d_n); end
    vectors++; if (HI !== 32'd2 || LO !== 32'd14) begin miscompares++; $display("FAIL div_result: got %0d rem %0d quo, want 2 14", HI, LO); end
    tick;
  endtask

  task automatic test_div_zero;
    wr_hi = 1'b1; wr_data = 32'h11; tick; wr_hi = 1'b0;
    wr_lo = 1'b1; wr_data = 32'h22; tick; wr_lo = 1'b0;
    issue(1'b1, 32'h1234, 32'd0);
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_pulse: got %b want 1", div_zero); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL dz_idle: busy %b done %b want 0 0", busy, done); end
    vectors++; if (dp_A !== 32'd100 || dp_B !== 32'd7) begin miscompares++; $display("FAIL dz_dp_hold: got %h %h want 64 7", dp_A, dp_B); end
    tick;
    vectors++; if (div_zero !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL dz_width: div_zero %b done %b want 0 0", div_zero, done); end
    vectors++; if (HI !== 32'h11 || LO !== 32'h22) begin miscompares++; $display("FAIL dz_hilo: got %h %h want 11 22", HI, LO); end
  endtask

  task automatic test_back_to_back;
    int b_n = 0, d_n = 0, s_n, bad;
    issue(1'b0, 32'd3, 32'd4);
    for (int n = 0; n < LAT; n++) begin
      b_n += int'(busy);
      d_n += int'(done);
      start = (n == 5 || n == 20);
      op = 1'b0; in_A = 32'd9; in_B = 32'd9;
      tick;
    end
    start = 1'b0;
    vectors++; if (b_n !== LAT || d_n !== 0 || done !== 1'b1) begin miscompares++; $display("FAIL busy_start_ignored: busy %0d early done %0d done %b want %0d 0 1", b_n, d_n, done, LAT); end
    vectors++; if (HI !== 32'd0 || LO !== 32'd12) begin miscompares++; $display("FAIL busy_start_result: got %h %h want 0 c", HI, LO); end
    issue(1'b0, 32'd5, 32'd6);
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL start_in_done: busy %b done %b want 1 0", busy, done); end
    watch_op(1'b0, 32'd5, 32'd6, 1'b1, LAT, b_n, s_n, d_n, bad);
    vectors++; if (done !== 1'b1 || LO !== 32'd30 || HI !== 32'd0 || bad !== 0) begin miscompares++; $display("FAIL second_op: done %b %h_%h bad %0d want 1 0_1e 0", done, HI, LO, bad); end
    tick;
  endtask

  task automatic test_reset_abort;
    int b_n, s_n, d_n, bad;
    issue(1'b1, 32'hAA, 32'h100);
    watch_op(1'b1, 32'hAA, 32'h100, 1'b0, LAT, b_n, s_n, d_n, bad);
    vectors++; if (HI !== 32'hAA || LO !== 32'd0) begin miscompares++; $display("FAIL abort_prior: got %h %h want aa 0", HI, LO); end
    tick;
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    watch_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10, b_n, s_n, d_n, bad);
    reset = 1'b1;
    tick;
    vectors++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin miscompares++; $display("FAIL abort_state: busy %b HI %h LO %h want 0 0 0", busy, HI, LO); end
    vectors++; if (dp_reset !== 1'b1 || dp_A !== 32'd0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_dp: dp_reset %b dp_A %h done %b want 1 0 0", dp_reset, dp_A, done); end
    reset = 1'b0;
    watch_op(1'b0, 32'd0, 32'd0, 1'b0, LAT + 6, b_n, s_n, d_n, bad);
    vectors++; if (d_n !== 0 || b_n !== 0) begin miscompares++; $display("FAIL abort_no_done: done %0d busy %0d want 0 0", d_n, b_n); end
  endtask

  task automatic test_wr_strobes;
    int b_n, s_n, d_n, bad;
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF; tick; wr_hi = 1'b0;
    vectors++; if (HI !== 32'hDEAD_BEEF || LO !== 32'd0) begin miscompares++; $display("FAIL mthi: got %h %h want deadbeef 0", HI, LO); end
    wr_lo = 1'b1; wr_data = 32'hCAFE_F00D; tick; wr_lo = 1'b0;
    vectors++; if (LO !== 32'hCAFE_F00D || HI !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mtlo: got %h %h want deadbeef cafef00d", HI, LO); end
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h1234_5678; tick; wr_hi = 1'b0; wr_lo = 1'b0;
    vectors++; if (HI !== 32'h1234_5678 || LO !== 32'h1234_5678) begin miscompares++; $display("FAIL mt_both: got %h %h want 12345678 x2", HI, LO); end
    wr_hi = 1'b1; wr_data = 32'h55;
    issue(1'b0, 32'd2, 32'd3);
    wr_hi = 1'b0;
    vectors++; if (HI !== 32'h55 || busy !== 1'b1) begin miscompares++; $display("FAIL mt_with_start: HI %h busy %b want 55 1", HI, busy); end
    watch_op(1'b0, 32'd2, 32'd3, 1'b0, 5, b_n, s_n, d_n, bad);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF; tick; wr_hi = 1'b0; wr_lo = 1'b0;
    vectors++; if (HI !== 32'h55 || LO !== 32'h1234_5678) begin miscompares++; $display("FAIL mt_while_busy: got %h %h want 55 12345678", HI, LO); end
    watch_op(1'b0, 32'd2, 32'd3, 1'b0, LAT - 6, b_n, s_n, d_n, bad);
    vectors++; if (done !== 1'b1 || HI !== 32'd0 || LO !== 32'd6) begin miscompares++; $display("FAIL mt_overwritten: done %b %h_%h want 1 0_6", done, HI, LO); end
    tick;
  endtask

  task automatic test_random_ops;
    int b_n, s_n, d_n, bad;
    logic        o;
    logic [31:0] a, b, hi0, lo0;
    logic [63:0] exp;
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      if (o && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'd1;
      hi0 = HI; lo0 = LO;
      exp = ref_result(o, a, b);
      issue(o, a, b);
      if (o && b == 32'd0) begin
        vectors++; if (div_zero !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rnd_dz[%0d]: div_zero %b busy %b want 1 0", i, div_zero, busy); end
        tick;
        vectors++; if (HI !== hi0 || LO !== lo0 || done !== 1'b0) begin miscompares++; $display("FAIL rnd_dz_hold[%0d]: %h_%h done %b want %h_%h 0", i, HI, LO, done, hi0, lo0); end
      end else begin
        watch_op(o, a, b, 1'b1, LAT, b_n, s_n, d_n, bad);
        vectors++; if (done !== 1'b1 || s_n !== CYCLES || bad !== 0) begin miscompares++; $display("FAIL rnd_seq[%0d]: done %b steps %0d bad %0d want 1 %0d 0", i, done, s_n, bad, CYCLES); end
        vectors++; if ({HI, LO} !== exp) begin miscompares++; $display("FAIL rnd_result[%0d] op %b a %h b %h: got %h_%h want %h", i, o, a, b, HI, LO, exp); end
        tick;
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult_basic;
    test_div_basic;
    test_div_zero;
    test_back_to_back;
    test_reset_abort;
    test_wr_strobes;
    test_random_ops;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
